adc_capture_scheduler: RTL and testbench

//  Sequences the LTC2324-16 capture engine and its AXIS DMA path. Config and commands from PS GPIO/AXI-lite come in here.

---
 rtl/adc_capture_scheduler_if.sv | 43 ++++
 rtl/adc_capture_scheduler.sv | 153 +++++++++++++++
 tb/tb_adc_capture_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_scheduler_if.sv
// Signal bundle between the PS command/config side, the capture engine and the
// capture scheduler. The scheduler connects through the slave modport.
interface adc_capture_scheduler_if #(
    parameter int CNT_W = 32
);
    logic             cfg_start;
    logic             cfg_stop;
    logic [CNT_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_period;
    logic [15:0]      cfg_burst;
    logic [7:0]       cfg_ch_sel;

    // Engine handshake: sample_start is a level request held until the engine
    // answers with st_clr (sampled on the rising clock edge); samp_valid is a
    // single-cycle qualifier per sample set and has no back-pressure.
    logic             st_clr;
    logic             samp_valid;
    logic             sample_start;
    logic [CNT_W-1:0] sample_len;
    logic [7:0]       ch_sel;

    logic             busy;
    logic             cap_done;
    logic             sched_done;
    logic [15:0]      cap_idx;
    logic             err_timeout;
    logic             err_overrun;
    logic             err_cfg;

    modport master (
        output cfg_start, cfg_stop, cfg_len, cfg_period, cfg_burst, cfg_ch_sel,
               st_clr, samp_valid,
        input  sample_start, sample_len, ch_sel, busy, cap_done, sched_done,
               cap_idx, err_timeout, err_overrun, err_cfg
    );

    modport slave (
        input  cfg_start, cfg_stop, cfg_len, cfg_period, cfg_burst, cfg_ch_sel,
               st_clr, samp_valid,
        output sample_start, sample_len, ch_sel, busy, cap_done, sched_done,
               cap_idx, err_timeout, err_overrun, err_cfg
    );
endinterface

// File: rtl/adc_capture_scheduler.sv
// Sequences single, burst or continuous periodic captures of the LTC2324-16
// engine; flags ack timeout, period overrun and rejected configuration.
module adc_capture_scheduler #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int MIN_GAP     = 8,
    parameter int CNT_W       = 32
) (
    input  logic                   adc_clk,
    input  logic                   adc_rst,
    adc_capture_scheduler_if.slave bus,
    output logic [1:0]             dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, GAP = 2'd3} state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len_q, period_q;
    logic [CNT_W-1:0] ack_cnt, per_cnt, gap_cnt, samp_cnt;
    logic [15:0]      burst_q, cap_idx_q;
    logic [7:0]       ch_sel_q;
    logic             stop_pending, cap_done_q, sched_done_q;
    logic             err_timeout_q, err_overrun_q, err_cfg_q;

    logic start_ok, stop_now, last_samp, burst_met, ack_expired;
    logic period_hit, period_ok, gap_ok, enter_arm;

    always_comb begin
        start_ok    = bus.cfg_start && (bus.cfg_len != '0);
        stop_now    = stop_pending || bus.cfg_stop;
        last_samp   = bus.samp_valid && (samp_cnt == len_q - ONE);
        burst_met   = (burst_q != 16'd0) && (({1'b0, cap_idx_q} + 17'd1) == {1'b0, burst_q});
        ack_expired = (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));
        // Period timer starts at ARM entry, so leaving GAP at period-1 puts the
        // next ARM entry exactly cfg_period cycles after the previous one.
        period_hit  = (per_cnt >= period_q - ONE);
        period_ok   = (period_q == '0) || period_hit;
        gap_ok      = (gap_cnt >= CNT_W'(MIN_GAP));
        enter_arm   = (state_nxt == ARM) && (state != ARM);
    end

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = ARM;
            ARM: begin
                if (bus.st_clr)       state_nxt = RUN;
                else if (ack_expired) state_nxt = IDLE;
            end
            RUN: if (last_samp) state_nxt = (stop_now || burst_met) ? IDLE : GAP;
            GAP: begin
                if (stop_now)                  state_nxt = IDLE;
                else if (gap_ok && period_ok)  state_nxt = ARM;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.sample_start = (state == ARM);
        bus.busy         = (state != IDLE);
        dbg_state        = state;
    end

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            len_q         <= '0;
            period_q      <= '0;
            burst_q       <= '0;
            ch_sel_q      <= '0;
            cap_idx_q     <= '0;
            ack_cnt       <= '0;
            per_cnt       <= '0;
            gap_cnt       <= '0;
            samp_cnt      <= '0;
            stop_pending  <= 1'b0;
            cap_done_q    <= 1'b0;
            sched_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            err_cfg_q     <= 1'b0;
        end else begin
            cap_done_q   <= 1'b0;
            sched_done_q <= 1'b0;

            if (enter_arm) begin
                ack_cnt <= '0;
                per_cnt <= '0;
            end else begin
                if (state == ARM) ack_cnt <= ack_cnt + ONE;
                if (per_cnt != '1) per_cnt <= per_cnt + ONE;
            end

            if (state_nxt == GAP && state != GAP)  gap_cnt <= ONE;
            else if (state == GAP && !gap_ok)       gap_cnt <= gap_cnt + ONE;

            if (state == IDLE)          stop_pending <= start_ok && bus.cfg_stop;
            else if (state_nxt == IDLE) stop_pending <= 1'b0;
            else if (bus.cfg_stop)      stop_pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        len_q         <= bus.cfg_len;
                        period_q      <= bus.cfg_period;
                        burst_q       <= bus.cfg_burst;
                        ch_sel_q      <= bus.cfg_ch_sel;
                        cap_idx_q     <= '0;
                        samp_cnt      <= '0;
                        err_timeout_q <= 1'b0;
                        err_overrun_q <= 1'b0;
                        err_cfg_q     <= 1'b0;
                    end else if (bus.cfg_start) begin
                        err_cfg_q <= 1'b1;
                    end
                end
                ARM: begin
                    if (!bus.st_clr && ack_expired) begin
                        err_timeout_q <= 1'b1;
                        sched_done_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_samp) begin
                        samp_cnt   <= '0;
                        cap_done_q <= 1'b1;
                        if (cap_idx_q != 16'hFFFF) cap_idx_q <= cap_idx_q + 16'd1;
                        if (stop_now || burst_met)               sched_done_q  <= 1'b1;
                        else if (period_q != '0 && period_hit)   err_overrun_q <= 1'b1;
                    end else if (bus.samp_valid) begin
                        samp_cnt <= samp_cnt + ONE;
                    end
                end
                GAP: if (stop_now) sched_done_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.sample_len  = len_q;
    assign bus.ch_sel      = ch_sel_q;
    assign bus.cap_done    = cap_done_q;
    assign bus.sched_done  = sched_done_q;
    assign bus.cap_idx     = cap_idx_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_overrun = err_overrun_q;
    assign bus.err_cfg     = err_cfg_q;
endmodule

// File: tb/tb_adc_capture_scheduler.sv
// Bench for adc_capture_scheduler: engine model plus timestamp reference model
// derived from the scheduling rules (start spacing, gap, timeout, stop).
`timescale 1ns/1ps
module tb_adc_capture_scheduler;
    localparam int ACK_TIMEOUT = 100;
    localparam int MIN_GAP     = 8;
    localparam int CNT_W       = 32;

    logic       adc_clk = 1'b0;
    logic       adc_rst = 1'b1;
    logic [1:0] dbg_state;

    adc_capture_scheduler_if #(.CNT_W(CNT_W)) bus ();

    adc_capture_scheduler #(
        .ACK_TIMEOUT(ACK_TIMEOUT), .MIN_GAP(MIN_GAP), .CNT_W(CNT_W)
    ) dut (
        .adc_clk(adc_clk), .adc_rst(adc_rst), .bus(bus), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 adc_clk = ~adc_clk;

    int cyc = 0;
    always @(posedge adc_clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] start_q[$], done_q[$];
    logic [31:0] exp_start_q[$], exp_done_q[$];
    int          sched_cnt = 0, sched_cyc = 0, fall_cyc = 0;
    logic        ss_prev = 1'b0;
    int          eng_en = 0, eng_ack_dly = 0, eng_vgap = 0, eng_len = 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return {1'b0, bus.sample_start, bus.sample_len, bus.ch_sel, bus.busy, bus.cap_done,
                bus.sched_done, bus.cap_idx, bus.err_timeout, bus.err_overrun, bus.err_cfg};
    endfunction

    // Event monitor: timestamps are the index of the most recent rising edge.
    always @(negedge adc_clk) begin
        if (!adc_rst) begin
            if (bus.sample_start && !ss_prev) start_q.push_back(cyc);
            if (!bus.sample_start && ss_prev) fall_cyc = cyc;
            if (bus.cap_done) done_q.push_back(cyc);
            if (bus.sched_done) begin
                sched_cnt++;
                sched_cyc = cyc;
            end
        end
        ss_prev = bus.sample_start;
    end

    // Engine model: ack after eng_ack_dly cycles, then eng_len single-cycle
    // valids separated by eng_vgap idle cycles.
    initial begin
        bus.st_clr     = 1'b0;
        bus.samp_valid = 1'b0;
        forever begin
            @(negedge adc_clk);
            if (eng_en != 0 && bus.sample_start && !adc_rst) begin
                repeat (eng_ack_dly) @(negedge adc_clk);
                bus.st_clr = 1'b1;
                @(negedge adc_clk);
                bus.st_clr = 1'b0;
                for (int i = 0; i < eng_len; i++) begin
                    repeat (eng_vgap) @(negedge adc_clk);
                    bus.samp_valid = 1'b1;
                    @(negedge adc_clk);
                    bus.samp_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_sched(input int budget, input string tag);
        int n;
        n = 0;
        while (sched_cnt == 0 && n < budget) begin
            @(negedge adc_clk);
            n++;
        end
        check_val({tag, "_sched_seen"}, (sched_cnt != 0), 1);
    endtask

    // stop_mode: 0 none, 1 stop with start, 2 stop mid-RUN of first capture,
    // 3 stop in the GAP after the second capture.
    task automatic run_schedule(input int len, input int period, input int burst,
                                input int dly, input int vgap, input int stop_mode,
                                input string tag);
        logic [7:0]  chs;
        logic [31:0] exp_v, got_v;
        int c0, s, e, n_caps, exp_ovr, dur, exp_sched, n, stop_cyc;
        chs    = 8'($urandom_range(0, 255));
        n_caps = (stop_mode == 0) ? burst : ((stop_mode == 3) ? 2 : 1);
        dur    = dly + 1 + len * (vgap + 1);
        start_q.delete(); done_q.delete(); exp_start_q.delete(); exp_done_q.delete();
        sched_cnt   = 0;
        eng_ack_dly = dly; eng_vgap = vgap; eng_len = len; eng_en = 1;

        @(negedge adc_clk);
        c0 = cyc;
        bus.cfg_len    = CNT_W'(len);
        bus.cfg_period = CNT_W'(period);
        bus.cfg_burst  = 16'(burst);
        bus.cfg_ch_sel = chs;
        bus.cfg_stop   = (stop_mode == 1);
        bus.cfg_start  = 1'b1;
        @(negedge adc_clk);
        // cfg changes and a second start while busy must be ignored
        bus.cfg_stop   = 1'b0;
        bus.cfg_len    = CNT_W'($urandom_range(1, 50));
        bus.cfg_period = CNT_W'($urandom_range(0, 3));
        bus.cfg_burst  = 16'($urandom_range(0, 9));
        bus.cfg_ch_sel = 8'($urandom_range(0, 255));
        @(negedge adc_clk);
        bus.cfg_start  = 1'b0;

        s = c0 + 1;
        e = s;
        exp_ovr = 0;
        for (int i = 0; i < n_caps; i++) begin
            exp_start_q.push_back(s);
            e = s + dur;
            exp_done_q.push_back(e);
            if (i < n_caps - 1 || stop_mode == 3) begin
                if (period != 0 && e >= s + period) exp_ovr = 1;
                s = (period != 0 && s + period > e + MIN_GAP) ? s + period : e + MIN_GAP;
            end
        end
        exp_sched = e;

        if (stop_mode == 2) begin
            repeat (dly + 4) @(negedge adc_clk);
            bus.cfg_stop = 1'b1;
            @(negedge adc_clk);
            bus.cfg_stop = 1'b0;
        end else if (stop_mode == 3) begin
            n = 0;
            while (done_q.size() < 2 && n < 500) begin
                @(negedge adc_clk);
                n++;
            end
            stop_cyc     = cyc;
            exp_sched    = stop_cyc + 1;
            bus.cfg_stop = 1'b1;
            @(negedge adc_clk);
            bus.cfg_stop = 1'b0;
        end

        wait_sched(n_caps * (dur + period + MIN_GAP) + 50, tag);
        repeat (2) @(negedge adc_clk);

        check_val({tag, "_sched_cnt"}, sched_cnt, 1);
        check_val({tag, "_sched_cyc"}, sched_cyc, exp_sched);
        while (exp_start_q.size() > 0) begin
            exp_v = exp_start_q.pop_front();
            got_v = (start_q.size() > 0) ? start_q.pop_front() : '1;
            check_val({tag, "_start_cyc"}, got_v, exp_v);
        end
        check_val({tag, "_extra_starts"}, start_q.size(), 0);
        while (exp_done_q.size() > 0) begin
            exp_v = exp_done_q.pop_front();
            got_v = (done_q.size() > 0) ? done_q.pop_front() : '1;
            check_val({tag, "_done_cyc"}, got_v, exp_v);
        end
        check_val({tag, "_extra_dones"}, done_q.size(), 0);
        check_val({tag, "_cap_idx"}, bus.cap_idx, n_caps);
        check_val({tag, "_busy"}, bus.busy, 0);
        check_val({tag, "_err_overrun"}, bus.err_overrun, exp_ovr);
        check_val({tag, "_err_timeout"}, bus.err_timeout, 0);
        check_val({tag, "_err_cfg"}, bus.err_cfg, 0);
        check_val({tag, "_sample_len"}, bus.sample_len, len);
        check_val({tag, "_ch_sel"}, bus.ch_sel, chs);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0, n, r_len, r_per, r_bst, r_dly, r_vg;
        bus.cfg_start  = 1'b0;
        bus.cfg_stop   = 1'b0;
        bus.cfg_len    = '0;
        bus.cfg_period = '0;
        bus.cfg_burst  = '0;
        bus.cfg_ch_sel = '0;
        adc_rst = 1'b1;
        repeat (3) @(negedge adc_clk);
        check_val("rst_outs", outs_vec(), 0);
        adc_rst = 1'b0;
        @(negedge adc_clk);
        check_val("rst_idle_outs", outs_vec(), 0);

        // single capture, back-to-back valids
        run_schedule(4, 0, 1, 5, 0, 0, "t1");

        // stop in IDLE must not leak into the next schedule
        bus.cfg_stop = 1'b1;
        @(negedge adc_clk);
        bus.cfg_stop = 1'b0;
        run_schedule(2, 100, 3, 3, 1, 0, "t2");

        // capture longer than the period
        run_schedule(10, 20, 2, 2, 4, 0, "t3");

        // ack timeout: engine never answers
        eng_en = 0;
        start_q.delete();
        sched_cnt = 0;
        @(negedge adc_clk);
        c0 = cyc;
        bus.cfg_len = 4; bus.cfg_period = 0; bus.cfg_burst = 1; bus.cfg_start = 1'b1;
        @(negedge adc_clk);
        bus.cfg_start = 1'b0;
        wait_sched(ACK_TIMEOUT + 20, "t4");
        repeat (2) @(negedge adc_clk);
        check_val("t4_fall_cyc", fall_cyc, c0 + 1 + ACK_TIMEOUT);
        check_val("t4_sched_cyc", sched_cyc, c0 + 1 + ACK_TIMEOUT);
        check_val("t4_err_timeout", bus.err_timeout, 1);
        check_val("t4_busy", bus.busy, 0);
        check_val("t4_cap_idx", bus.cap_idx, 0);
        check_val("t4_starts", start_q.size(), 1);
        eng_en = 1;

        // stop handling in continuous mode
        run_schedule(6, 0, 0, 2, 3, 2, "t5_stop_run");
        run_schedule(3, 0, 0, 1, 1, 3, "t5_stop_gap");
        run_schedule(3, 0, 0, 2, 0, 1, "t5_stop_start");

        // zero-length start is rejected
        @(negedge adc_clk);
        bus.cfg_len = 0; bus.cfg_start = 1'b1;
        @(negedge adc_clk);
        bus.cfg_start = 1'b0;
        check_val("t5_err_cfg", bus.err_cfg, 1);
        check_val("t5_cfg_busy", bus.busy, 0);
        check_val("t5_cfg_sample_start", bus.sample_start, 0);
        check_val("t5_cfg_len_kept", bus.sample_len, 3);
        repeat (3) @(negedge adc_clk);
        check_val("t5_cfg_busy_later", bus.busy, 0);

        // asynchronous reset in the middle of a capture
        eng_ack_dly = 1; eng_vgap = 2; eng_len = 8; eng_en = 1;
        start_q.delete();
        @(negedge adc_clk);
        bus.cfg_len = 8; bus.cfg_period = 0; bus.cfg_burst = 2; bus.cfg_ch_sel = 8'h5A;
        bus.cfg_start = 1'b1;
        @(negedge adc_clk);
        bus.cfg_start = 1'b0;
        n = 0;
        while (start_q.size() == 0 && n < 50) begin
            @(negedge adc_clk);
            n++;
        end
        check_val("t6_started", start_q.size(), 1);
        repeat (8) @(negedge adc_clk);
        check_val("t6_busy_before", bus.busy, 1);
        #2 adc_rst = 1'b1;
        #1 check_val("t6_outs_zero", outs_vec(), 0);
        @(negedge adc_clk);
        adc_rst = 1'b0;
        repeat (40) @(negedge adc_clk);
        check_val("t6_idle_after", outs_vec(), 0);
        run_schedule(5, 0, 1, 2, 1, 0, "t6_restart");

        // randomized schedules
        for (int k = 0; k < 8; k++) begin
            r_len = $urandom_range(1, 6);
            r_per = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(10, 60);
            r_bst = $urandom_range(1, 4);
            r_dly = $urandom_range(0, 6);
            r_vg  = $urandom_range(0, 3);
            run_schedule(r_len, r_per, r_bst, r_dly, r_vg, 0, $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time %0t reached before the summary, required earlier finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
